ram_bus_ctrl: RTL and testbench

- Bus master for the single-port synchronous-write RAM: accepts read/fill requests over a valid/ready handshake and drives the RAM address, active-low write enable and shared tri-state data bus.
- Sits between the CPU/loader datapath and the RAM.
- Supports bursts: N-beat reads with per-beat response handshake, and N-beat fills that write one value to consecutive addresses.
- Guarantees no bus contention with the RAM's read driver.

---
 rtl/ram_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_ram_bus_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_ctrl.sv
// RAM bus master: valid/ready read and fill bursts onto a single-port RAM with a shared data bus.
// Write beat k lands at edge k+1; read data is valid 2 cycles after accept or handshake; a response stalls until rsp_ready.
module ram_bus_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  turn_q, turn_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b1;
      turn_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      turn_q      <= turn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // READ spends its first cycle (turn_q) letting the RAM take over the bus before capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && req_ready) state_d = req_write ? WRITE : READ;
      WRITE:   if (cnt_zero) state_d = IDLE;
      READ:    if (!turn_q) state_d = RESP;
      RESP:    if (rsp_ready) state_d = cnt_zero ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    turn_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          wdata_d = req_wdata;
          we_d    = !req_write;
          turn_d  = !req_write;
        end
      end
      WRITE: begin
        if (cnt_zero) begin
          we_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
        end
      end
      READ: begin
        if (!turn_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_data;
          rsp_last_d  = cnt_zero;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (!cnt_zero) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - LEN_WIDTH'(1);
            turn_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // The bus driver hangs off the same register as ram_we, so the two can never overlap.
  assign ram_data    = we_q ? {DATA_WIDTH{1'bz}} : wdata_q;
  assign ram_we      = we_q;
  assign ram_address = addr_q;
  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with a behavioural RAM, write/read scoreboards and a bus monitor.
module tb_ram_bus_ctrl;

  typedef struct packed {logic [7:0] a; logic [3:0] d;} wexp_t;
  typedef struct packed {logic [3:0] d; logic last;} rexp_t;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       rsp_last;
  logic [7:0] ram_address;
  logic       ram_we;
  wire  [3:0] ram_data;
  logic       busy;

  logic [3:0] ram [256];
  logic [3:0] exp_mem [256];
  wexp_t      wq [$];
  rexp_t      rq [$];
  int         n_chk;
  int         n_fail;
  int         rsp_cnt;
  logic       rnd_rdy;

  ram_bus_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .ram_address(ram_address), .ram_we(ram_we), .ram_data(ram_data), .busy(busy)
  );

  // Behavioural RAM: combinational read driver while ram_we is high, synchronous write.
  assign ram_data = ram_we ? ram[ram_address] : 4'bzzzz;
  always @(posedge clk) if (!ram_we) ram[ram_address] <= ram_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (ram_we) chk("bus_contention", 32'(ram_data), 32'(ram[ram_address]));
    if (!reset && !ram_we) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(wq.size()), 32'd1);
      else begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e.a));
        chk("wr_data", 32'(ram_data), 32'(e.d));
        exp_mem[e.a] = e.d;
      end
    end
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (rq.size() == 0) chk("rsp_unexpected", 32'(rq.size()), 32'd1);
      else begin
        rexp_t r;
        r = rq.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(r.d));
        chk("rsp_last", 32'(rsp_last), 32'(r.last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [3:0] l,
                          input logic [3:0] d, output int waited);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk("req_timeout", 32'(n < 200), 32'd1);
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] ai;
      ai = a + 8'(i);
      if (w) wq.push_back('{a: ai, d: d});
      else rq.push_back('{d: exp_mem[ai], last: (i == int'(l))});
    end
    step();
    req_valid = 1'b0;
    waited = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready && rq.size() == 0 && wq.size() == 0) && n < 400) begin
      if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < 400), 32'd1);
    rsp_ready = 1'b1;
  endtask

  initial begin
    int w, lat, cnt0;
    n_chk = 0; n_fail = 0; rsp_cnt = 0; rnd_rdy = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 4'h0;
      exp_mem[i] = 4'h0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Write burst of four, then read it back.
    send_req(1'b1, 8'h10, 4'd3, 4'hA, w);
    cnt0 = 0;
    while (!ram_we && cnt0 < 40) begin
      cnt0++;
      step();
    end
    chk("wr_we_low_cycles", 32'(cnt0), 32'd4);
    wait_idle();
    cnt0 = rsp_cnt;
    send_req(1'b0, 8'h10, 4'd3, 4'h0, w);
    wait_idle();
    chk("rd_beats", 32'(rsp_cnt - cnt0), 32'd4);

    // Stalled response holds stable and the address does not move.
    rsp_ready = 1'b0;
    cnt0 = rsp_cnt;
    send_req(1'b0, 8'h10, 4'd0, 4'h0, w);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("stall_rsp_timeout", 32'(lat < 20), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", 32'(rsp_rdata), 32'hA);
      chk("stall_last", 32'(rsp_last), 32'd1);
      chk("stall_addr", 32'(ram_address), 32'h10);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("stall_beats", 32'(rsp_cnt - cnt0), 32'd1);

    // Address wrap at the top of the RAM.
    send_req(1'b1, 8'hFE, 4'd2, 4'h5, w);
    wait_idle();
    chk("wrap_mem_00", 32'(exp_mem[0]), 32'h5);
    send_req(1'b0, 8'hFE, 4'd2, 4'h0, w);
    wait_idle();

    // Random mixed bursts with random consumer backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), w);
      wait_idle();
    end
    rnd_rdy = 1'b0;

    // Reset during the second beat of a long write.
    send_req(1'b1, 8'h40, 4'd7, 4'hC, w);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(ram_we), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    wq.delete();
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_mem40", 32'(exp_mem[8'h40]), 32'hC);
    send_req(1'b0, 8'h40, 4'd2, 4'h0, w);
    wait_idle();

    // Request held across a write into a read; measure acceptance wait and read latency.
    send_req(1'b1, 8'h80, 4'd1, 4'h3, w);
    send_req(1'b0, 8'h80, 4'd0, 4'h0, w);
    chk("b2b_accept_wait", 32'(w), 32'd2);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("read_latency", 32'(lat), 32'd2);
    wait_idle();

    // Full-length read burst.
    cnt0 = rsp_cnt;
    send_req(1'b0, 8'hF8, 4'hF, 4'h0, w);
    wait_idle();
    chk("max_len_beats", 32'(rsp_cnt - cnt0), 32'd16);

    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
